// File: rtl/parallel_to_serial.sv
// parallel_to_serial
//   Transmit-side serialiser for the EEG link. Each WIDTH-bit word accepted on
//   the input handshake is shifted out on sEEG, one bit per CLK_DIV clk
//   cycles. sclk is generated alongside so that its rising edge falls in the
//   middle of every bit. A one-word holding register accepts the next word
//   while the current one is being shifted.
//
//   After every frame there is a GAP of CLK_DIV cycles with frame low, so the
//   receiver can tell where one word ends and the next begins.
//
// Handshake (valid/ready):
//   A word transfers on a rising clk edge where in_valid && in_ready are both
//   high. The source must hold data_in and in_valid stable until that edge.
//   in_ready depends only on rst and the hold register, never on in_valid.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   rst       synchronous reset, active-high
//   data_in   word to transmit (WIDTH bits)
//   in_valid  data_in is valid
//   in_ready  a word can be accepted this cycle (combinational)
//   sEEG      serial data out (registered)
//   sclk      bit clock, rising edge at mid-bit (registered)
//   frame     high while a word's bits are on sEEG (registered)
//   done      one-cycle pulse on the last cycle of a frame (registered)
module parallel_to_serial #(
  parameter int WIDTH     = 4,
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sEEG,
  output logic             sclk,
  output logic             frame,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  // sclk goes high once the divider reaches floor(CLK_DIV/2); for odd
  // CLK_DIV the high phase is therefore the longer one.
  localparam logic [DW-1:0] SCLK_HI  = DW'(CLK_DIV / 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DW-1:0]     div_q, div_d;
  logic              seeg_q, seeg_d;
  logic              sclk_q, sclk_d;
  logic              frame_q, frame_d;
  logic              done_q, done_d;

  logic              accept;
  logic              cur_bit_d;

  assign in_ready = !rst && !hold_full_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_d       = bit_q;
    div_d       = div_q;

    case (state_q)
      S_IDLE: begin
        bit_d = '0;
        div_d = '0;
        if (hold_full_q) begin
          // Only reachable when a word was taken on the final GAP edge.
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = S_SHIFT;
        end else if (accept) begin
          shift_d = data_in;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (accept) begin
          hold_d      = data_in;
          hold_full_d = 1'b1;
        end
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = S_GAP;
          end else begin
            bit_d = bit_q + 1'b1;
            // The bit on the line always sits at the output end of shift_q.
            if (MSB_FIRST != 0) shift_d = shift_q << 1;
            else                shift_d = shift_q >> 1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_GAP: begin
        // accept and drain are exclusive: accept needs hold_full_q == 0.
        if (accept) begin
          hold_d      = data_in;
          hold_full_d = 1'b1;
        end
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = S_SHIFT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        bit_d   = '0;
        div_d   = '0;
      end
    endcase

    // Outputs are computed from the next state so that the registered
    // outputs line up with the state they describe.
    cur_bit_d = (MSB_FIRST != 0) ? shift_d[WIDTH-1] : shift_d[0];
    frame_d   = (state_d == S_SHIFT);
    seeg_d    = frame_d && cur_bit_d;
    sclk_d    = frame_d && (div_d >= SCLK_HI);
    done_d    = frame_d && (bit_d == BIT_LAST) && (div_d == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_q       <= '0;
      div_q       <= '0;
      seeg_q      <= 1'b0;
      sclk_q      <= 1'b0;
      frame_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      seeg_q      <= seeg_d;
      sclk_q      <= sclk_d;
      frame_q     <= frame_d;
      done_q      <= done_d;
    end
  end

  assign sEEG  = seeg_q;
  assign sclk  = sclk_q;
  assign frame = frame_q;
  assign done  = done_q;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: a table of single-word vectors, hand-written
// corner sequences, and randomized traffic checked against a cycle-indexed
// reference model that places each word's frame on a timeline.
module tb_parallel_to_serial;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int FL = W * D;        // frame length in cycles
  localparam int FD = (W + 1) * D;  // frame plus gap

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         in_ready, seeg, sclk, frame, done;

  logic         rst2 = 1'b1;
  logic         in_valid2 = 1'b0;
  logic [W-1:0] data_in2 = '0;
  logic         in_ready2, seeg2, sclk2, frame2, done2;

  parallel_to_serial #(.WIDTH(W), .CLK_DIV(D), .MSB_FIRST(0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .sEEG(seeg), .sclk(sclk), .frame(frame), .done(done)
  );

  parallel_to_serial #(.WIDTH(W), .CLK_DIV(3), .MSB_FIRST(1)) dut2 (
    .clk(clk), .rst(rst2), .data_in(data_in2), .in_valid(in_valid2),
    .in_ready(in_ready2), .sEEG(seeg2), .sclk(sclk2), .frame(frame2), .done(done2)
  );

  // ---------------- counters and check tasks ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;   // index of the cycle currently shown on the outputs

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted word gets the cycle on which its frame starts. Outputs for
  // any cycle follow from the offset into that word's frame.
  typedef struct {
    logic [W-1:0] data;
    int           acc;    // edge on which it was accepted
    int           start;  // first cycle with frame=1
  } word_t;
  word_t words[$];

  function automatic logic model_hold_full(input int c);
    foreach (words[i])
      if (words[i].acc < c && words[i].start > c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_exp(input int c, output logic s, output logic sc,
                                    output logic f, output logic dn);
    s = 1'b0; sc = 1'b0; f = 1'b0; dn = 1'b0;
    foreach (words[i]) begin
      int idx;
      idx = c - words[i].start;
      if (idx >= 0 && idx < FL) begin
        s  = words[i].data[idx / D];
        sc = (idx % D) >= (D / 2);
        f  = 1'b1;
        dn = (idx == FL - 1);
      end
    end
  endfunction

  // ---------------- scoreboard: words as a receiver sees them ----------------
  logic [W-1:0] exp_q[$];
  logic         rx_q[$];
  int           frame_start_q[$];
  logic [W-1:0] rx_word = '0;
  int           rx_cnt = 0;
  int           act_cnt = 0;
  logic         sclk_prev = 1'b0;
  logic         frame_prev = 1'b0;

  always @(negedge clk) begin
    if (seeg || sclk || frame || done) act_cnt++;
    if (frame && !frame_prev) begin
      frame_start_q.push_back(cyc);
      rx_cnt = 0;
    end
    if (frame && sclk && !sclk_prev) begin
      rx_q.push_back(seeg);
      if (rx_cnt < W) rx_word[rx_cnt] = seeg;
      rx_cnt++;
    end
    if (done) begin
      if (exp_q.size() == 0) check_int("sb_unexpected_word", 1, 0);
      else check_word("sb_word", rx_word, exp_q.pop_front());
    end
    sclk_prev  = sclk;
    frame_prev = frame;
  end

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [W-1:0] d, input logic r,
                      output logic acc, output logic rdy_seen);
    logic  rdy_exp, es, esc, ef, ed;
    word_t w;
    rst = r; in_valid = v; data_in = d;
    #1;
    rdy_seen = in_ready;
    rdy_exp  = !r && !model_hold_full(cyc);
    check_bit("in_ready", in_ready, rdy_exp);
    acc = v && rdy_exp;
    if (acc) begin
      w.data = d;
      w.acc  = cyc;
      if (words.size() > 0 && words[$].start <= cyc && cyc <= words[$].start + FD - 1)
        w.start = (cyc < words[$].start + FD - 1) ? words[$].start + FD : cyc + 2;
      else
        w.start = cyc + 1;
      words.push_back(w);
      exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      words.delete();
      exp_q.delete();
    end
    while (words.size() > 0 && words[0].start + FD < cyc) void'(words.pop_front());
    model_exp(cyc, es, esc, ef, ed);
    check_bit("sEEG", seeg, es);
    check_bit("sclk", sclk, esc);
    check_bit("frame", frame, ef);
    check_bit("done", done, ed);
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         rdy, s, sc, f, dn;
  } vec_t;
  vec_t tv[22];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc, rdy, got;
    int   acc_edge, e0;
    logic one_bits[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic b2b_bits[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset: in_ready low and all outputs zero while rst is held.
    repeat (3) step(1'b0, '0, 1'b1, acc, rdy);
    rst2 = 1'b0;

    // Single word 4'b1011: cycle c relative to the accept edge.
    for (int i = 0; i < 22; i++) begin
      int c;
      c = i + 1;
      tv[i].v   = (i == 0);
      tv[i].d   = 4'b1011;
      tv[i].rdy = 1'b1;
      tv[i].f   = (c >= 1 && c <= 16);
      tv[i].s   = tv[i].f ? one_bits[(c - 1) / 4] : 1'b0;
      tv[i].sc  = tv[i].f && (((c - 1) % 4) >= 2);
      tv[i].dn  = (c == 16);
    end
    for (int i = 0; i < 22; i++) begin
      step(tv[i].v, tv[i].d, 1'b0, acc, rdy);
      check_bit("tbl_ready", rdy, tv[i].rdy);
      check_bit("tbl_seeg", seeg, tv[i].s);
      check_bit("tbl_sclk", sclk, tv[i].sc);
      check_bit("tbl_frame", frame, tv[i].f);
      check_bit("tbl_done", done, tv[i].dn);
    end

    // Back-to-back: A then 5 held on in_valid.
    frame_start_q.delete(); rx_q.delete();
    e0 = cyc;
    step(1'b1, 4'hA, 1'b0, acc, rdy);
    step(1'b1, 4'h5, 1'b0, acc, rdy);
    check_bit("b2b_second_ready", rdy, 1'b1);
    repeat (44) step(1'b0, 4'h0, 1'b0, acc, rdy);
    check_int("b2b_frames", frame_start_q.size(), 2);
    if (frame_start_q.size() == 2) begin
      check_int("b2b_first_start", frame_start_q[0], e0 + 1);
      check_int("b2b_spacing", frame_start_q[1] - frame_start_q[0], 20);
    end
    check_int("b2b_bits", rx_q.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < rx_q.size()) check_bit("b2b_bit", rx_q[k], b2b_bits[k]);

    // Backpressure: a third word waits until the hold register drains.
    frame_start_q.delete();
    e0 = cyc;
    step(1'b1, 4'h3, 1'b0, acc, rdy);
    step(1'b1, 4'hC, 1'b0, acc, rdy);
    got = 1'b0;
    acc_edge = -1;
    for (int k = 0; k < 60 && !got; k++) begin
      step(1'b1, 4'h9, 1'b0, acc, rdy);
      if (rdy) begin
        got = 1'b1;
        acc_edge = cyc - 1;
      end
    end
    check_bit("bp_accepted", got, 1'b1);
    check_int("bp_accept_edge", acc_edge, e0 + 21);
    repeat (70) step(1'b0, 4'h0, 1'b0, acc, rdy);
    check_int("bp_frames", frame_start_q.size(), 3);
    check_int("bp_words_left", exp_q.size(), 0);

    // Reset during bit 2 with the hold register full.
    step(1'b1, 4'h6, 1'b0, acc, rdy);
    step(1'b1, 4'hF, 1'b0, acc, rdy);
    repeat (8) step(1'b0, 4'h0, 1'b0, acc, rdy);
    step(1'b0, 4'h0, 1'b1, acc, rdy);
    check_bit("rst_seeg", seeg, 1'b0);
    check_bit("rst_sclk", sclk, 1'b0);
    check_bit("rst_frame", frame, 1'b0);
    check_bit("rst_done", done, 1'b0);
    frame_start_q.delete();
    repeat (30) step(1'b0, 4'h0, 1'b0, acc, rdy);
    check_int("rst_no_frame", frame_start_q.size(), 0);
    check_bit("rst_ready", rdy, 1'b1);

    // Idle for 50 cycles after reset.
    step(1'b0, 4'h0, 1'b1, acc, rdy);
    act_cnt = 0;
    repeat (50) step(1'b0, 4'h0, 1'b0, acc, rdy);
    check_int("idle_activity", act_cnt, 0);
    check_bit("idle_ready", rdy, 1'b1);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      logic r, v;
      logic [W-1:0] d;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 2) != 0);
      d = W'($urandom_range(0, 15));
      step(v, d, r, acc, rdy);
    end
    repeat (60) step(1'b0, 4'h0, 1'b0, acc, rdy);
    check_int("rand_words_left", exp_q.size(), 0);

    // MSB-first, CLK_DIV=3 instance: send 4'b1000.
    in_valid2 = 1'b1;
    data_in2  = 4'b1000;
    #1;
    check_bit("m3_ready", in_ready2, 1'b1);
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      logic f;
      f = (i < 12);
      check_bit("m3_seeg", seeg2, f && (i / 3 == 0));
      check_bit("m3_sclk", sclk2, f && ((i % 3) >= 1));
      check_bit("m3_frame", frame2, f);
      check_bit("m3_done", done2, (i == 11));
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
